// File: rtl/mux_rr_arbiter_if.sv
// Shared-channel bundle for the 4-requester round-robin mux arbiter.
// The master side drives requests and data; the slave side (the arbiter)
// returns the grant, the select bits, valid and the registered output.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic       valid;
    logic       y;

    modport master (
        output req,
        output d,
        input  gnt,
        input  s1,
        input  s2,
        input  valid,
        input  y
    );

    modport slave (
        input  req,
        input  d,
        output gnt,
        output s1,
        output s2,
        output valid,
        output y
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter plus registered 4:1 single-bit mux.
// One owner at a time; each tenure is bounded to MAX_HOLD cycles while
// other requesters wait. The selected data bit is registered one cycle
// behind the grant, so the shared line behaves as a single clocked unit.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] ptr_reg, ptr_next;
    logic [1:0] owner_reg, owner_next;
    logic [7:0] hold_reg, hold_next;
    logic [3:0] gnt_reg, gnt_next;
    logic       valid_reg, valid_next;
    logic       y_reg;

    logic [3:0] req;
    logic [3:0] others;
    logic [2:0] pick_all;
    logic [2:0] pick_oth;
    logic       grant_now;
    logic [1:0] grant_idx;

    assign req = bus.req;

    // Requests from everyone except the current owner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_others
        assign others[gi] = req[gi] & (owner_reg != 2'(gi));
    end

    // Round-robin search: scan base+1, base+2, base+3, base (mod 4).
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = base + 2'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign pick_all = rr_pick(req, ptr_reg);
    // In BUSY ptr equals owner, so this serves both release and preempt.
    assign pick_oth = rr_pick(others, owner_reg);

    // Next-state and next-output decode for the grant FSM.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        hold_next  = hold_reg;
        gnt_next   = gnt_reg;
        valid_next = valid_reg;
        grant_now  = 1'b0;
        grant_idx  = 2'd0;

        case (state_reg)
            IDLE: begin
                if (pick_all[2]) begin
                    grant_now = 1'b1;
                    grant_idx = pick_all[1:0];
                end
            end
            BUSY: begin
                if (!req[owner_reg]) begin
                    // Release wins over preempt; hand off with no idle bubble.
                    if (pick_oth[2]) begin
                        grant_now = 1'b1;
                        grant_idx = pick_oth[1:0];
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                        valid_next = 1'b0;
                    end
                end else if (hold_reg >= HOLD_LAST && pick_oth[2]) begin
                    // ">=" so a competitor arriving after saturation-free
                    // solo holding still preempts on its first sampled edge.
                    grant_now = 1'b1;
                    grant_idx = pick_oth[1:0];
                end else if (hold_reg != 8'hFF) begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (grant_now) begin
            state_next = BUSY;
            ptr_next   = grant_idx;
            owner_next = grant_idx;
            hold_next  = 8'd0;
            gnt_next   = 4'b0001 << grant_idx;
            valid_next = 1'b1;
        end
    end

    // Arbitration state and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 2'd3;
            owner_reg <= 2'd0;
            hold_reg  <= 8'd0;
            gnt_reg   <= 4'b0000;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            hold_reg  <= hold_next;
            gnt_reg   <= gnt_next;
            valid_reg <= valid_next;
        end
    end

    // Registered mux output, driven by the select/valid from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg <= 1'b0;
        end else begin
            y_reg <= valid_reg ? bus.d[owner_reg] : 1'b0;
        end
    end

    // Select bits track the owner and hold their value while idle.
    assign bus.gnt   = gnt_reg;
    assign bus.s1    = owner_reg[1];
    assign bus.s2    = owner_reg[0];
    assign bus.valid = valid_reg;
    assign bus.y     = y_reg;

endmodule
